// File: rtl/voice_pkg.sv
// Shared types and constants for the voice-capture path.
// Holds the record-session state encoding and the PDM sample word width.
// Ports: none (package).
package voice_pkg;

    typedef enum logic [1:0] {
        REC_IDLE   = 2'd0,
        REC_WAKE   = 2'd1,
        REC_RECORD = 2'd2,
        REC_DONE   = 2'd3
    } rec_state_t;

    // Word width produced by PDM_sample and stored in the sample RAM.
    localparam int SAMPLE_W = 32;

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM microphone clock divider: mic_clk toggles every CLK_DIV/2 clk cycles while run is high.
// Ports: clk, rst (async, active-high), run (enable), mic_clk (divided clock, low whenever run is low).
// First rising edge CLK_DIV/2 cycles after run rises; 50% duty.
module pdm_clk_gen #(
    parameter int CLK_DIV = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic mic_clk
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mic_q, mic_d;

    // Counter and phase are held at zero whenever the session is not running,
    // so every session starts from the same phase.
    always_comb begin
        cnt_d = '0;
        mic_d = 1'b0;
        if (run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                mic_d = ~mic_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                mic_d = mic_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            mic_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mic_q <= mic_d;
        end
    end

    // Gate with run so the pin drops in the very cycle the session leaves RECORD.
    assign mic_clk = mic_q & run;

endmodule

// File: rtl/pdm_record_ctrl.sv
// Voice-capture session sequencer: wakes the mic, enables PDM_sample, stores its words in sample RAM.
// Ports: rec_start/rec_stop requests in; mic_clk, count_en to mic/sampler; samp_wr/samp_data from
// sampler; mem_we/mem_addr/mem_wdata to RAM (registered, 1 cycle after samp_wr); word_count/busy/full/done status.
module pdm_record_ctrl
    import voice_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAKE_CYCLES = 4096,
    parameter int CLK_DIV     = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rec_start,
    input  logic                rec_stop,
    output logic                mic_clk,
    output logic                count_en,
    input  logic                samp_wr,
    input  logic [SAMPLE_W-1:0] samp_data,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [SAMPLE_W-1:0] mem_wdata,
    output logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                full,
    output logic                done
);

    localparam int WC_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WC_W-1:0]   WAKE_LAST = WC_W'(WAKE_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    rec_state_t          state_q, state_d;
    logic [WC_W-1:0]     wake_cnt_q, wake_cnt_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                full_q, full_d;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [SAMPLE_W-1:0] mem_wdata_q;
    logic                done_q;

    logic                run;
    logic                wr_acc;
    logic                last_word;

    // Words are only taken while recording; anything the sampler produces
    // outside RECORD (it is not enabled then) is dropped.
    assign wr_acc    = (state_q == REC_RECORD) && samp_wr;
    assign last_word = wr_acc && ((word_count_q + 1'b1) == DEPTH_CNT);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            REC_IDLE:   if (rec_start) state_d = REC_WAKE;
            // A stop during wake-up wins over wake expiry in the same cycle.
            REC_WAKE:   if (rec_stop) state_d = REC_DONE;
                        else if (wake_cnt_q == WAKE_LAST) state_d = REC_RECORD;
            REC_RECORD: if (rec_stop || last_word) state_d = REC_DONE;
            REC_DONE:   state_d = REC_IDLE;
            default:    state_d = REC_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        run      = 1'b0;
        count_en = 1'b0;
        busy     = 1'b0;
        case (state_q)
            REC_WAKE:   begin run = 1'b1; busy = 1'b1; end
            REC_RECORD: begin run = 1'b1; busy = 1'b1; count_en = 1'b1; end
            default:    ;
        endcase
    end

    // ---------------- wake counter and session status ----------------
    always_comb begin
        wake_cnt_d   = (state_q == REC_WAKE) ? wake_cnt_q + 1'b1 : '0;
        word_count_d = word_count_q;
        full_d       = full_q;
        if ((state_q == REC_IDLE) && rec_start) begin
            word_count_d = '0;
            full_d       = 1'b0;
        end else if (wr_acc) begin
            word_count_d = word_count_q + 1'b1;
            if (last_word) full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wake_cnt_q   <= '0;
            word_count_q <= '0;
            full_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            wake_cnt_q   <= wake_cnt_d;
            word_count_q <= word_count_d;
            full_q       <= full_d;
            mem_we_q     <= wr_acc;
            if (wr_acc) begin
                mem_addr_q  <= word_count_q[ADDR_W-1:0];
                mem_wdata_q <= samp_data;
            end
            // DONE lasts exactly one cycle, so this is a single-cycle pulse.
            done_q <= (state_d == REC_DONE);
        end
    end

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .mic_clk (mic_clk)
    );

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign full       = full_q;
    assign done       = done_q;

endmodule
